// File: rtl/fifo_axis_pkg.sv
// rtl/fifo_axis_pkg.sv - shared types and constants for the FIFO-to-AXIS packer
package fifo_axis_pkg;

  typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} pkt_state_t;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_WIDTH = $clog2(BUF_DEPTH + 1);

  // A one-beat packet still needs a 1-bit counter so the compare stays legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_axis_packer_if.sv
// rtl/fifo_axis_packer_if.sv - FIFO read port plus AXIS master stream bundle
interface fifo_axis_packer_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  o_fifo_rd_en;
  logic [DATA_WIDTH-1:0] i_fifo_rd_data;
  logic                  i_fifo_rd_valid;
  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] o_m_axis_tdata;
  logic                  o_m_axis_tvalid;
  logic                  o_m_axis_tlast;
  logic                  i_m_axis_tready;

  modport master (
    output o_fifo_rd_en,
    input  i_fifo_rd_data,
    input  i_fifo_rd_valid,
    input  i_fifo_empty,
    output o_m_axis_tdata,
    output o_m_axis_tvalid,
    output o_m_axis_tlast,
    input  i_m_axis_tready
  );

  modport slave (
    input  o_fifo_rd_en,
    output i_fifo_rd_data,
    output i_fifo_rd_valid,
    output i_fifo_empty,
    input  o_m_axis_tdata,
    input  o_m_axis_tvalid,
    input  o_m_axis_tlast,
    output i_m_axis_tready
  );

endinterface

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - two-entry output buffer absorbing FIFO read latency and backpressure
module axis_skid_buf
  import fifo_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_s_rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_WIDTH-1:0]  occ,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  dropped
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic                  rd_idx;
  logic                  wr_idx;
  logic                  do_pop;
  logic                  do_push;

  assign do_pop    = pop && (occ != '0);
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign do_push   = push && ((occ != OCC_WIDTH'(BUF_DEPTH)) || do_pop);
  assign dropped   = push && !do_push;
  assign head_data = mem[rd_idx];

  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_idx <= 1'b0;
      wr_idx <= 1'b0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= ~wr_idx;
      end
      if (do_pop) begin
        rd_idx <= ~rd_idx;
      end
      occ <= occ + OCC_WIDTH'(do_push) - OCC_WIDTH'(do_pop);
    end
  end

endmodule

// File: rtl/fifo_axis_packer.sv
// rtl/fifo_axis_packer.sv - drains a sync FIFO into an AXIS master with tlast every PACKET_LEN beats
module fifo_axis_packer
  import fifo_axis_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int PACKET_LEN    = 16,
  parameter int PKT_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_s_rst,
  fifo_axis_packer_if.master       bus,
  output logic [PKT_CNT_WIDTH-1:0] o_pkt_count,
  output logic                     o_busy,
  output logic                     o_overflow
);

  localparam int                    BEAT_WIDTH = cnt_width(PACKET_LEN);
  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT  = BEAT_WIDTH'(PACKET_LEN - 1);

  logic [OCC_WIDTH-1:0]  occ;
  logic [OCC_WIDTH:0]    credit;
  logic                  inflight;
  logic [BEAT_WIDTH-1:0] beat_cnt;
  pkt_state_t            state;
  logic                  tvalid;
  logic                  last_beat;
  logic                  pop;
  logic                  dropped;

  assign tvalid    = (occ != '0);
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign pop       = tvalid && bus.i_m_axis_tready;

  // Slots already claimed, crediting back the head that leaves this cycle.
  assign credit = {1'b0, occ} + (OCC_WIDTH + 1)'(inflight) - (OCC_WIDTH + 1)'(pop);

  assign bus.o_fifo_rd_en    = !i_s_rst && !bus.i_fifo_empty && (credit < (OCC_WIDTH + 1)'(BUF_DEPTH));
  assign bus.o_m_axis_tvalid = tvalid;
  assign bus.o_m_axis_tlast  = tvalid && last_beat;
  assign o_busy              = (state == OPEN);

  axis_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .i_clk    (i_clk),
    .i_s_rst  (i_s_rst),
    .push     (bus.i_fifo_rd_valid),
    .push_data(bus.i_fifo_rd_data),
    .pop      (pop),
    .occ      (occ),
    .head_data(bus.o_m_axis_tdata),
    .dropped  (dropped)
  );

  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      inflight    <= 1'b0;
      beat_cnt    <= '0;
      state       <= IDLE;
      o_pkt_count <= '0;
      o_overflow  <= 1'b0;
    end else begin
      // A new request in the same cycle as the previous word's arrival keeps the credit held.
      if (bus.o_fifo_rd_en) begin
        inflight <= 1'b1;
      end else if (bus.i_fifo_rd_valid) begin
        inflight <= 1'b0;
      end

      if (dropped) begin
        o_overflow <= 1'b1;
      end

      if (pop) begin
        if (last_beat) begin
          beat_cnt    <= '0;
          state       <= IDLE;
          o_pkt_count <= o_pkt_count + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          state    <= OPEN;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_axis_packer.sv
// tb/tb_fifo_axis_packer.sv - directed bench for fifo_axis_packer across four configurations
module tb_fifo_axis_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   sel = 0;
  logic tready = 1'b0;

  // Shared sync FIFO model with one-cycle read latency, routed to the selected DUT.
  logic [7:0] fmem [256];
  logic [7:0] wr_ptr = '0;
  logic [7:0] rd_ptr = '0;
  logic [7:0] rd_data = '0;
  logic       rd_valid = 1'b0;
  logic       fifo_empty;
  assign fifo_empty = (wr_ptr == rd_ptr);

  fifo_axis_packer_if #(.DATA_WIDTH(8)) if_a ();
  fifo_axis_packer_if #(.DATA_WIDTH(8)) if_b ();
  fifo_axis_packer_if #(.DATA_WIDTH(8)) if_c ();
  fifo_axis_packer_if #(.DATA_WIDTH(8)) if_d ();

  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic [1:0]  cnt_d;
  logic        busy_a, busy_b, busy_c, busy_d;
  logic        ovf_a, ovf_b, ovf_c, ovf_d;

  assign if_a.i_fifo_empty    = (sel != 0) || fifo_empty;
  assign if_a.i_fifo_rd_valid = (sel == 0) && rd_valid;
  assign if_a.i_fifo_rd_data  = rd_data;
  assign if_a.i_m_axis_tready = (sel == 0) && tready;
  assign if_b.i_fifo_empty    = (sel != 1) || fifo_empty;
  assign if_b.i_fifo_rd_valid = (sel == 1) && rd_valid;
  assign if_b.i_fifo_rd_data  = rd_data;
  assign if_b.i_m_axis_tready = (sel == 1) && tready;
  assign if_c.i_fifo_empty    = (sel != 2) || fifo_empty;
  assign if_c.i_fifo_rd_valid = (sel == 2) && rd_valid;
  assign if_c.i_fifo_rd_data  = rd_data;
  assign if_c.i_m_axis_tready = (sel == 2) && tready;
  assign if_d.i_fifo_empty    = (sel != 3) || fifo_empty;
  assign if_d.i_fifo_rd_valid = (sel == 3) && rd_valid;
  assign if_d.i_fifo_rd_data  = rd_data;
  assign if_d.i_m_axis_tready = (sel == 3) && tready;

  fifo_axis_packer #(.DATA_WIDTH(8), .PACKET_LEN(16), .PKT_CNT_WIDTH(16)) dut_a (
    .i_clk(clk), .i_s_rst(rst), .bus(if_a), .o_pkt_count(cnt_a), .o_busy(busy_a), .o_overflow(ovf_a));
  fifo_axis_packer #(.DATA_WIDTH(8), .PACKET_LEN(8), .PKT_CNT_WIDTH(16)) dut_b (
    .i_clk(clk), .i_s_rst(rst), .bus(if_b), .o_pkt_count(cnt_b), .o_busy(busy_b), .o_overflow(ovf_b));
  fifo_axis_packer #(.DATA_WIDTH(8), .PACKET_LEN(4), .PKT_CNT_WIDTH(16)) dut_c (
    .i_clk(clk), .i_s_rst(rst), .bus(if_c), .o_pkt_count(cnt_c), .o_busy(busy_c), .o_overflow(ovf_c));
  fifo_axis_packer #(.DATA_WIDTH(8), .PACKET_LEN(1), .PKT_CNT_WIDTH(2)) dut_d (
    .i_clk(clk), .i_s_rst(rst), .bus(if_d), .o_pkt_count(cnt_d), .o_busy(busy_d), .o_overflow(ovf_d));

  logic        o_rd_en, o_tvalid, o_tlast, o_busy, o_ovf;
  logic [7:0]  o_tdata;
  logic [15:0] o_cnt;

  always_comb begin
    o_rd_en = if_a.o_fifo_rd_en; o_tvalid = if_a.o_m_axis_tvalid; o_tlast = if_a.o_m_axis_tlast;
    o_tdata = if_a.o_m_axis_tdata; o_cnt = cnt_a; o_busy = busy_a; o_ovf = ovf_a;
    case (sel)
      1: begin
        o_rd_en = if_b.o_fifo_rd_en; o_tvalid = if_b.o_m_axis_tvalid; o_tlast = if_b.o_m_axis_tlast;
        o_tdata = if_b.o_m_axis_tdata; o_cnt = cnt_b; o_busy = busy_b; o_ovf = ovf_b;
      end
      2: begin
        o_rd_en = if_c.o_fifo_rd_en; o_tvalid = if_c.o_m_axis_tvalid; o_tlast = if_c.o_m_axis_tlast;
        o_tdata = if_c.o_m_axis_tdata; o_cnt = cnt_c; o_busy = busy_c; o_ovf = ovf_c;
      end
      3: begin
        o_rd_en = if_d.o_fifo_rd_en; o_tvalid = if_d.o_m_axis_tvalid; o_tlast = if_d.o_m_axis_tlast;
        o_tdata = if_d.o_m_axis_tdata; o_cnt = {14'b0, cnt_d}; o_busy = busy_d; o_ovf = ovf_d;
      end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_ptr   <= wr_ptr;
    end else if (o_rd_en && !fifo_empty) begin
      rd_data  <= fmem[rd_ptr];
      rd_ptr   <= rd_ptr + 8'd1;
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         credit = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;
  logic [7:0] got_d [$];
  logic       got_l [$];
  int         got_c [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    got_d.delete(); got_l.delete(); got_c.delete();
    credit = 0; prev_stall = 1'b0;
  endtask

  task automatic step(input logic tr, input int nload, input int base);
    @(negedge clk);
    for (int i = 0; i < nload; i++) begin
      fmem[wr_ptr] = 8'(base + i);
      wr_ptr       = wr_ptr + 8'd1;
    end
    tready = tr;
    #1;
    cyc++;
    if (rst) begin
      credit = 0; prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", o_tvalid, 1);
        chk("hold_data", o_tdata, prev_data);
        chk("hold_last", o_tlast, prev_last);
      end
      if (o_rd_en) chk("credit", (credit - int'(o_tvalid && tr)) < 2, 1);
      if (o_tvalid && tr) begin
        got_d.push_back(o_tdata); got_l.push_back(o_tlast); got_c.push_back(cyc);
      end
      credit     = credit + int'(o_rd_en) - int'(o_tvalid && tr);
      prev_stall = o_tvalid && !tr;
      prev_data  = o_tdata;
      prev_last  = o_tlast;
    end
  endtask

  task automatic run_until(input int n, input logic tr, input int budget);
    for (int k = 0; k < budget && got_d.size() < n; k++) step(tr, 0, 0);
    chk("beat_total", got_d.size(), n);
  endtask

  initial begin
    // Reset values
    repeat (3) step(0, 0, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_tlast", o_tlast, 0);
    chk("rst_tdata", o_tdata, 0);
    chk("rst_cnt", o_cnt, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovf", o_ovf, 0);
    rst = 1'b0;

    // Streaming: 32 words, PACKET_LEN 16
    clear_log();
    step(1, 32, 0);
    chk("lat_rd_en_n", o_rd_en, 1);
    chk("lat_tvalid_n", o_tvalid, 0);
    step(1, 0, 0);
    chk("lat_tvalid_n1", o_tvalid, 0);
    step(1, 0, 0);
    chk("lat_tvalid_n2", o_tvalid, 1);
    chk("lat_tdata_n2", o_tdata, 0);
    run_until(32, 1, 60);
    for (int i = 0; i < got_d.size(); i++) begin
      chk($sformatf("st_data%0d", i), got_d[i], i);
      chk($sformatf("st_last%0d", i), got_l[i], (i == 15 || i == 31));
    end
    if (got_c.size() == 32) chk("st_back_to_back", got_c[31] - got_c[0], 31);
    step(1, 0, 0); step(1, 0, 0);
    chk("st_pkt_count", o_cnt, 2);
    chk("st_busy", o_busy, 0);
    chk("st_ovf", o_ovf, 0);

    // Backpressure: 10 words, long stall then alternating tready
    clear_log();
    for (int k = 0; k < 60 && got_d.size() < 10; k++) begin
      step((k >= 4) && (k % 2 == 0), (k == 0) ? 10 : 0, 0);
      if (k == 3) chk("bp_rd_en_full", o_rd_en, 0);
    end
    chk("bp_beats", got_d.size(), 10);
    for (int i = 0; i < got_d.size(); i++) chk($sformatf("bp_data%0d", i), got_d[i], i);
    step(1, 0, 0); step(1, 0, 0);
    chk("bp_ovf", o_ovf, 0);
    chk("bp_busy", o_busy, 1);
    chk("bp_pkt_count", o_cnt, 2);

    // Reset mid-packet on PACKET_LEN 8
    clear_log();
    sel = 1;
    step(1, 7, 0);
    run_until(5, 1, 20);
    repeat (3) step(0, 0, 0);
    chk("mid_busy", o_busy, 1);
    chk("mid_tvalid", o_tvalid, 1);
    rst = 1'b1;
    step(0, 0, 0); step(0, 0, 0);
    chk("mid_rst_tvalid", o_tvalid, 0);
    chk("mid_rst_tlast", o_tlast, 0);
    chk("mid_rst_cnt", o_cnt, 0);
    chk("mid_rst_busy", o_busy, 0);
    rst = 1'b0;
    clear_log();
    step(1, 8, 100);
    run_until(8, 1, 30);
    for (int i = 0; i < got_d.size(); i++) begin
      chk($sformatf("rf_data%0d", i), got_d[i], 100 + i);
      chk($sformatf("rf_last%0d", i), got_l[i], (i == 7));
    end
    step(1, 0, 0); step(1, 0, 0);
    chk("rf_pkt_count", o_cnt, 1);
    chk("rf_busy", o_busy, 0);

    // Sparse input on PACKET_LEN 4
    clear_log();
    sel = 2;
    for (int w = 0; w < 8; w++) begin
      step(1, 1, w);
      step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
      chk($sformatf("sp_busy%0d", w), o_busy, (w % 4 != 3));
    end
    chk("sp_beats", got_d.size(), 8);
    for (int i = 0; i < got_d.size(); i++) begin
      chk($sformatf("sp_data%0d", i), got_d[i], i);
      chk($sformatf("sp_last%0d", i), got_l[i], (i % 4 == 3));
    end
    chk("sp_pkt_count", o_cnt, 2);
    chk("sp_ovf", o_ovf, 0);

    // PACKET_LEN 1 with 2-bit packet counter wrap
    clear_log();
    sel = 3;
    for (int w = 0; w < 5; w++) begin
      step(1, 1, 50 + w);
      step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
      chk($sformatf("p1_cnt%0d", w), o_cnt, (w + 1) % 4);
      chk($sformatf("p1_busy%0d", w), o_busy, 0);
    end
    chk("p1_beats", got_d.size(), 5);
    for (int i = 0; i < got_d.size(); i++) begin
      chk($sformatf("p1_data%0d", i), got_d[i], 50 + i);
      chk($sformatf("p1_last%0d", i), got_l[i], 1);
    end
    chk("p1_ovf", o_ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
